regfile_bypass_nrmw: RTL and testbench
======================================

// Module: regfile_bypass_nrmw
//
// PURPOSE
// Parametrised multi-read/multi-write flop-based integer/FP register file for the
// out-of-order core; next generation of the fixed 3R/2W 96x65 regfile.
// Read addresses are registered and the array is read combinationally in the
// following cycle. Adds: configurable port counts, same-cycle write-to-read bypass,
// hardwired zero register, deterministic write-conflict priority, and sticky error flags.
//
// PARAMETERS
// NUM_REGS  96  number of architectural/physical entries
// DATA_W    65  entry width (bits)
// ADDR_W    7   address width; must satisfy 2**ADDR_W >= NUM_REGS
// NUM_RD    3   number of read ports
// NUM_WR    2   number of write ports
// BYPASS    1   1 = forward same-cycle writes to matching read ports
// ZERO_REG  1   1 = entry 0 reads as 0 and ignores writes
//
// PORTS
// clock          in   1               single clock; all state updates on posedge
// reset          in   1               asynchronous, active-high
// rd_addr        in   NUM_RD*ADDR_W   read address, port i at [i*ADDR_W +: ADDR_W]
// rd_data        out  NUM_RD*DATA_W   read data, port i at [i*DATA_W +: DATA_W]
// wr_valid       in   NUM_WR          write enable per port
// wr_addr        in   NUM_WR*ADDR_W   write address per port
// wr_data        in   NUM_WR*DATA_W   write data per port
// conflict_err   out  1               sticky: two valid writes hit the same entry
// range_err      out  1               sticky: valid write or read address >= NUM_REGS
//
// BEHAVIOUR
// - Reset (async assert, deasserted synchronously by the SoC): every array entry = 0,
//   every registered read address = 0, conflict_err = 0, range_err = 0.
//   rd_data therefore = 0 on all ports during and right after reset.
// - Read latency 1: rd_addr sampled at edge E; rd_data valid through cycle E..E+1.
//   No read enable; ports always sample.
// - Array read: rd_data[i] = array[raddr_q[i]], with array state after edge E.
//   Writes committed at edge E are visible.
// - Bypass (BYPASS=1): if wr_valid[j] and wr_addr[j]==raddr_q[i] in the current cycle,
//   rd_data[i] = wr_data[j] combinationally.
//   Highest-index matching j wins. Bypass does not apply to entry 0 when ZERO_REG=1.
//   BYPASS=0: the array value is returned; the new value is seen next cycle.
// - Writes: on posedge, for each valid j with wr_addr[j] < NUM_REGS:
//   array[wr_addr[j]] <= wr_data[j].
//   Same-entry collision: highest-index port wins.
//   conflict_err sets at that edge if the address is not the zero register.
//   Writes to entry 0 with ZERO_REG=1 are dropped silently (no conflict flagged).
// - ZERO_REG=1: raddr_q==0 forces rd_data = 0 regardless of array/bypass.
// - Out of range: write with addr >= NUM_REGS is dropped.
//   Read of raddr_q >= NUM_REGS returns 0.
//   Either case sets range_err at the next edge.
// - Error flags: sticky until reset; they never block operation.
// - Reset mid-operation: in-flight writes at the reset edge are discarded.
//   Array is cleared asynchronously.
// - Sim-only (ifndef SYNTHESIS): assertion fires on conflict_err rising.
//   Message names both ports.
//
// TESTING
// 1. Reset, then read ports 0..2 at addrs 5,6,7 -> rd_data all 0, both err flags 0.
// 2. Write 65'h1_DEAD_BEEF_0000_0001 to entry 5 at edge E; set rd_addr0=5 at E+1.
//    Expect rd_data0 = that value after E+1 (BYPASS=0 and 1).
// 3. BYPASS=1: raddr_q0=9 while wr_valid[1], wr_addr=9, wr_data=0x123 in the same cycle.
//    Expect rd_data0=0x123 in that cycle. With BYPASS=0, rd_data0 = old value.
// 4. wr0 and wr1 both to entry 20 (0xAA / 0xBB) -> entry 20 = 0xBB, conflict_err=1 and stays set.
//    Repeat to entry 0 -> entry stays 0, no new conflict.
// 5. Write 0x55 to entry 0, read addr 0 -> rd_data=0.
//    Write to addr 100 (NUM_REGS=96) -> dropped, range_err=1.
// 6. Assert reset mid-stream after filling entries 1..95 -> all outputs 0 at once.
//    Post-reset reads of 1..95 return 0.

Source files
------------

// File: rtl/regfile_bypass_nrmw.sv
// Flop-based multi-port register file with 1-cycle registered read addresses,
// same-cycle write-to-read bypass, optional hardwired zero entry, fixed
// write-collision priority (highest port wins) and sticky error flags.

module regfile_bypass_nrmw #(
  parameter int NUM_REGS = 96,
  parameter int DATA_W   = 65,
  parameter int ADDR_W   = 7,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [NUM_WR-1:0]          wr_valid,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  output logic                       conflict_err,
  output logic                       range_err
);

  // One extra bit so NUM_REGS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] REGS_LIM  = (ADDR_W+1)'(NUM_REGS);
  localparam logic            BYPASS_EN = (BYPASS != 0);
  localparam logic            ZERO_EN   = (ZERO_REG != 0);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < REGS_LIM);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_EN && (a == {ADDR_W{1'b0}});
  endfunction

  logic [ADDR_W-1:0] raddr_d  [NUM_RD];
  logic [ADDR_W-1:0] raddr_q  [NUM_RD];
  logic [DATA_W-1:0] array_d  [NUM_REGS];
  logic [DATA_W-1:0] array_q  [NUM_REGS];

  logic [ADDR_W-1:0] wa_s     [NUM_WR];
  logic [ADDR_W-1:0] w_idx_s  [NUM_WR];
  logic [DATA_W-1:0] wd_s     [NUM_WR];
  logic              wok_s    [NUM_WR];

  logic [ADDR_W-1:0] rd_idx_s [NUM_RD];
  logic [DATA_W-1:0] rd_val_s [NUM_RD];

  logic conflict_s, conflict_d, conflict_q;
  logic range_s, range_d, range_q;
  int   conf_a_s, conf_b_s;

  // Unpack the read address bus for the address registers.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      raddr_d[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Decode write ports: a write commits only when in range and not to the zero entry.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wa_s[j]    = wr_addr[j*ADDR_W +: ADDR_W];
      wd_s[j]    = wr_data[j*DATA_W +: DATA_W];
      wok_s[j]   = wr_valid[j] && in_range(wa_s[j]) && !is_zero_reg(wa_s[j]);
      w_idx_s[j] = wok_s[j] ? wa_s[j] : {ADDR_W{1'b0}};
    end
  end

  // Next array state; ascending port order makes the highest port win a collision.
  always_comb begin
    array_d = array_q;
    for (int j = 0; j < NUM_WR; j++) begin
      array_d[w_idx_s[j]] = wok_s[j] ? wd_s[j] : array_d[w_idx_s[j]];
    end
  end

  // Detect committed writes colliding on one entry and remember the first pair.
  always_comb begin
    conflict_s = 1'b0;
    conf_a_s   = 0;
    conf_b_s   = 0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (!conflict_s && wok_s[a] && wok_s[b] && (wa_s[a] == wa_s[b])) begin
          conflict_s = 1'b1;
          conf_a_s   = a;
          conf_b_s   = b;
        end else begin
          conflict_s = conflict_s;
        end
      end
    end
  end

  // Out-of-range write requests or held read addresses; sticky flags accumulate.
  always_comb begin
    range_s = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      range_s = range_s | (wr_valid[j] & ~in_range(wa_s[j]));
    end
    for (int i = 0; i < NUM_RD; i++) begin
      range_s = range_s | ~in_range(raddr_q[i]);
    end
    conflict_d = conflict_q | conflict_s;
    range_d    = range_q | range_s;
  end

  // Read path: array value, overridden by the highest matching write, then forced to 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_idx_s[i] = in_range(raddr_q[i]) ? raddr_q[i] : {ADDR_W{1'b0}};
      rd_val_s[i] = in_range(raddr_q[i]) ? array_q[rd_idx_s[i]] : {DATA_W{1'b0}};
      for (int j = 0; j < NUM_WR; j++) begin
        rd_val_s[i] = (BYPASS_EN && wr_valid[j] && (wa_s[j] == raddr_q[i]))
                      ? wd_s[j] : rd_val_s[i];
      end
      rd_val_s[i] = (reset || !in_range(raddr_q[i]) || is_zero_reg(raddr_q[i]))
                    ? {DATA_W{1'b0}} : rd_val_s[i];
      rd_data[i*DATA_W +: DATA_W] = rd_val_s[i];
    end
  end

  // Read address registers and sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RD; i++) begin
        raddr_q[i] <= {ADDR_W{1'b0}};
      end
      conflict_q <= 1'b0;
      range_q    <= 1'b0;
    end else begin
      raddr_q    <= raddr_d;
      conflict_q <= conflict_d;
      range_q    <= range_d;
    end
  end

  // Storage array; cleared asynchronously, so writes in flight at reset are lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        array_q[r] <= {DATA_W{1'b0}};
      end
    end else begin
      array_q <= array_d;
    end
  end

  assign conflict_err = conflict_q;
  assign range_err    = range_q;

`ifndef SYNTHESIS
  regfile_bypass_nrmw_chk u_chk (
    .clock      (clock),
    .reset      (reset),
    .conflict_q (conflict_q),
    .conflict_d (conflict_d),
    .port_a     (conf_a_s),
    .port_b     (conf_b_s)
  );
`endif

endmodule

`ifndef SYNTHESIS
// Simulation-only monitor: reports the write ports involved when conflict_err rises.
module regfile_bypass_nrmw_chk (
  input logic clock,
  input logic reset,
  input logic conflict_q,
  input logic conflict_d,
  input int   port_a,
  input int   port_b
);

  // Announce the colliding port pair on the edge that sets the sticky flag.
  always @(posedge clock) begin
    if (!reset && conflict_d && !conflict_q) begin
      $info("regfile_bypass_nrmw: conflict_err rising, write ports %0d and %0d hit the same entry",
            port_a, port_b);
    end
  end

endmodule
`endif

// File: tb/tb_regfile_bypass_nrmw.sv
// Directed bench for regfile_bypass_nrmw: one instance with bypass, one without,
// both driven by identical stimulus.

module tb_regfile_bypass_nrmw;

  localparam int DW = 65;
  localparam int AW = 7;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [3*AW-1:0] rd_addr = '0;
  logic [1:0]      wr_valid = '0;
  logic [2*AW-1:0] wr_addr = '0;
  logic [2*DW-1:0] wr_data = '0;

  logic [3*DW-1:0] rd_data_b, rd_data_nb;
  logic            conflict_b, conflict_nb, range_b, range_nb;

  int checks   = 0;
  int failures = 0;

  localparam logic [DW-1:0] V2 = 65'h1_DEAD_BEEF_0000_0001;

  regfile_bypass_nrmw #(.BYPASS(1)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .conflict_err(conflict_b), .range_err(range_b)
  );

  regfile_bypass_nrmw #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .conflict_err(conflict_nb), .range_err(range_nb)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rb(input int p);
    return rd_data_b[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rnb(input int p);
    return rd_data_nb[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] fill_val(input int i);
    return {1'b1, 32'hC0DE_0000, 32'(i)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {7'(a2), 7'(a1), 7'(a0)};
  endtask

  task automatic set_wr(input int p, input int addr, input logic [DW-1:0] data);
    wr_valid[p]          = 1'b1;
    wr_addr[p*AW +: AW]  = 7'(addr);
    wr_data[p*DW +: DW]  = data;
  endtask

  task automatic clr_wr();
    wr_valid = 2'b00;
  endtask

  initial begin
    // Reset
    #1 reset = 1'b1;
    #1;
    check_val("rst_rd0", rb(0), 65'd0);
    check_val("rst_rd1", rb(1), 65'd0);
    check_val("rst_rd2", rb(2), 65'd0);
    tick();
    tick();
    reset = 1'b0;

    // 1: reads of untouched entries
    set_rd(5, 6, 7);
    tick();
    check_val("t1_rd0", rb(0), 65'd0);
    check_val("t1_rd1", rb(1), 65'd0);
    check_val("t1_rd2", rb(2), 65'd0);
    check_val("t1_conflict", 65'(conflict_b), 65'd0);
    check_val("t1_range", 65'(range_b), 65'd0);

    // 2: write entry 5 (and 9 on the other port), read it next cycle
    set_rd(1, 6, 7);
    set_wr(0, 5, V2);
    set_wr(1, 9, 65'h77);
    tick();
    clr_wr();
    set_rd(5, 6, 7);
    #1;
    check_val("t2_rd_other", rb(0), 65'd0);
    tick();
    check_val("t2_rd0_byp", rb(0), V2);
    check_val("t2_rd0_nobyp", rnb(0), V2);

    // 3: same-cycle bypass on entry 9
    set_rd(9, 6, 7);
    tick();
    set_wr(1, 9, 65'h123);
    #1;
    check_val("t3_byp_new", rb(0), 65'h123);
    check_val("t3_nobyp_old", rnb(0), 65'h77);
    tick();
    clr_wr();
    #1;
    check_val("t3_nobyp_next", rnb(0), 65'h123);
    check_val("t3_byp_next", rb(0), 65'h123);

    // 4b/5a: colliding writes to entry 0 are dropped, no bypass, no conflict
    set_rd(0, 6, 7);
    tick();
    set_wr(0, 0, 65'h55);
    set_wr(1, 0, 65'h66);
    #1;
    check_val("t4_zero_byp", rb(0), 65'd0);
    tick();
    clr_wr();
    #1;
    check_val("t4_zero_rd", rb(0), 65'd0);
    check_val("t4_zero_noconf", 65'(conflict_b), 65'd0);

    // 4a: colliding writes to entry 20, highest port wins
    set_rd(20, 6, 7);
    tick();
    set_wr(0, 20, 65'hAA);
    set_wr(1, 20, 65'hBB);
    #1;
    check_val("t4_byp_prio", rb(0), 65'hBB);
    check_val("t4_nobyp_old", rnb(0), 65'd0);
    check_val("t4_conf_pre", 65'(conflict_b), 65'd0);
    tick();
    clr_wr();
    #1;
    check_val("t4_entry20", rb(0), 65'hBB);
    check_val("t4_entry20_nb", rnb(0), 65'hBB);
    check_val("t4_conf_set", 65'(conflict_b), 65'd1);
    tick();
    tick();
    check_val("t4_conf_sticky", 65'(conflict_b), 65'd1);
    check_val("t4_range_clr", 65'(range_b), 65'd0);

    // 5b: out-of-range write dropped, range_err set
    set_wr(0, 100, 65'h99);
    tick();
    clr_wr();
    #1;
    check_val("t5_range_set", 65'(range_nb), 65'd1);
    check_val("t5_rd20_intact", rb(0), 65'hBB);
    set_rd(20, 100, 7);
    tick();
    check_val("t5_rd_oor", rb(1), 65'd0);

    // 6: fill 1..95, reset mid-stream, everything cleared
    for (int i = 1; i < 96; i++) begin
      set_wr(0, i, fill_val(i));
      tick();
    end
    clr_wr();
    set_rd(1, 50, 95);
    tick();
    check_val("t6_fill1", rb(0), fill_val(1));
    check_val("t6_fill50", rb(1), fill_val(50));
    check_val("t6_fill95", rnb(2), fill_val(95));
    set_wr(0, 30, 65'hABC);
    #2 reset = 1'b1;
    #1;
    check_val("t6_rst_rd0", rb(0), 65'd0);
    check_val("t6_rst_rd1", rb(1), 65'd0);
    check_val("t6_rst_rd2", rnb(2), 65'd0);
    check_val("t6_rst_conf", 65'(conflict_b), 65'd0);
    check_val("t6_rst_range", 65'(range_nb), 65'd0);
    tick();
    clr_wr();
    reset = 1'b0;
    for (int base = 1; base < 96; base += 3) begin
      set_rd(base, base + 1, base + 2);
      tick();
      check_val("t6_post_rd0", rb(0), 65'd0);
      check_val("t6_post_rd1", rb(1), 65'd0);
      check_val("t6_post_rd2", rnb(2), 65'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
